gpio_pad_bank: RTL and testbench

//  Parametrised successor to the fixed 4-pin status GPIO: a WIDTH-channel pad controller between the
//  SoC register bus and the board IOBUF array (pins_read/write/writeEnable).

---
 rtl/gpio_pad_bank.sv | 185 ++++++++++++++++++
 tb/tb_gpio_pad_bank.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: bus-mapped direction/open-drain control, synchronised and debounced
// inputs, and edge-triggered interrupts with write-one-to-clear pending bits.
module gpio_pad_bank #(
  parameter int WIDTH     = 8,
  parameter int DEB_W     = 16,
  parameter int DEB_RESET = 0
) (
  input  logic             io_clock,
  input  logic             io_reset,
  input  logic             io_bus_valid,
  input  logic             io_bus_write,
  input  logic [2:0]       io_bus_addr,
  input  logic [31:0]      io_bus_wdata,
  output logic             io_bus_ready,
  output logic [31:0]      io_bus_rdata,
  input  logic [WIDTH-1:0] io_pins_read,
  output logic [WIDTH-1:0] io_pins_write,
  output logic [WIDTH-1:0] io_pins_writeEnable,
  output logic             io_interrupt
);

  localparam logic [DEB_W-1:0] LP_DEB_RESET = DEB_W'(DEB_RESET);

  localparam logic [2:0] A_IN       = 3'd0;
  localparam logic [2:0] A_OUT      = 3'd1;
  localparam logic [2:0] A_DIR      = 3'd2;
  localparam logic [2:0] A_OD       = 3'd3;
  localparam logic [2:0] A_RISE_EN  = 3'd4;
  localparam logic [2:0] A_FALL_EN  = 3'd5;
  localparam logic [2:0] A_PENDING  = 3'd6;
  localparam logic [2:0] A_DEBOUNCE = 3'd7;

  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_od;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_pending;
  logic [DEB_W-1:0] r_debounce;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable_prev;
  logic [WIDTH-1:0] r_pad_w;
  logic [WIDTH-1:0] r_pad_oe;
  logic             r_irq;

  logic             w_accept;
  logic             w_wr;
  logic             w_rd;
  logic             w_deb_wr;
  logic [WIDTH-1:0] w_pend_clr;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [31:0]      w_rdata_mux;
  logic             w_unused;

  // A request is not sampled while ready is high, so held valid gives one access per 2 cycles.
  assign w_accept   = io_bus_valid & ~r_ready;
  assign w_wr       = w_accept & io_bus_write;
  assign w_rd       = w_accept & ~io_bus_write;
  assign w_deb_wr   = w_wr & (io_bus_addr == A_DEBOUNCE);
  assign w_pend_clr = (w_wr && io_bus_addr == A_PENDING) ? io_bus_wdata[WIDTH-1:0] : '0;
  assign w_unused   = ^io_bus_wdata;

  assign w_rise = w_stable & ~r_stable_prev;
  assign w_fall = ~w_stable & r_stable_prev;
  assign w_set  = (w_rise & r_rise_en) | (w_fall & r_fall_en);

  always_comb begin
    w_rdata_mux = '0;
    case (io_bus_addr)
      A_IN:       w_rdata_mux[WIDTH-1:0] = w_stable;
      A_OUT:      w_rdata_mux[WIDTH-1:0] = r_out;
      A_DIR:      w_rdata_mux[WIDTH-1:0] = r_dir;
      A_OD:       w_rdata_mux[WIDTH-1:0] = r_od;
      A_RISE_EN:  w_rdata_mux[WIDTH-1:0] = r_rise_en;
      A_FALL_EN:  w_rdata_mux[WIDTH-1:0] = r_fall_en;
      A_PENDING:  w_rdata_mux[WIDTH-1:0] = r_pending;
      A_DEBOUNCE: w_rdata_mux[DEB_W-1:0] = r_debounce;
      default:    w_rdata_mux = '0;
    endcase
  end

  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_out      <= '0;
      r_dir      <= '0;
      r_od       <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_debounce <= LP_DEB_RESET;
    end else begin
      r_ready <= w_accept;
      if (w_rd) begin
        r_rdata <= w_rdata_mux;
      end
      if (w_wr) begin
        case (io_bus_addr)
          A_OUT:      r_out      <= io_bus_wdata[WIDTH-1:0];
          A_DIR:      r_dir      <= io_bus_wdata[WIDTH-1:0];
          A_OD:       r_od       <= io_bus_wdata[WIDTH-1:0];
          A_RISE_EN:  r_rise_en  <= io_bus_wdata[WIDTH-1:0];
          A_FALL_EN:  r_fall_en  <= io_bus_wdata[WIDTH-1:0];
          A_DEBOUNCE: r_debounce <= io_bus_wdata[DEB_W-1:0];
          default:    ;
        endcase
      end
    end
  end

  // A new edge overrides a coincident W1C of the same bit.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      r_pending     <= '0;
      r_stable_prev <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_pending     <= (r_pending & ~w_pend_clr) | w_set;
      r_stable_prev <= w_stable;
      r_irq         <= |r_pending;
    end
  end

  // Open-drain pins only ever pull low: drive enable follows DIR & ~OUT, data fixed at 0.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      r_pad_w  <= '0;
      r_pad_oe <= '0;
    end else begin
      r_pad_w  <= r_out & ~r_od;
      r_pad_oe <= r_dir & ~(r_od & r_out);
    end
  end

  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_pins_read;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_deb
      logic [DEB_W-1:0] r_cnt;
      logic             r_bit;

      // Counter reaching DEBOUNCE means the new level has been seen DEBOUNCE+1 cycles in a row.
      always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (w_deb_wr) begin
          r_cnt <= '0;
        end else if (r_debounce == '0 || r_sync2[gi] == r_bit) begin
          r_cnt <= '0;
          r_bit <= r_sync2[gi];
        end else if (r_cnt >= r_debounce) begin
          r_cnt <= '0;
          r_bit <= r_sync2[gi];
        end else begin
          r_cnt <= r_cnt + DEB_W'(1);
        end
      end

      assign w_stable[gi] = r_bit;
    end
  endgenerate

  assign io_bus_ready        = r_ready;
  assign io_bus_rdata        = r_rdata;
  assign io_pins_write       = r_pad_w;
  assign io_pins_writeEnable = r_pad_oe;
  assign io_interrupt        = r_irq;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Bench for gpio_pad_bank: expected values are queued when stimulus is applied and
// popped when the DUT output is sampled (#1 after the rising edge).
module tb_gpio_pad_bank;

  localparam int WIDTH     = 8;
  localparam int DEB_W     = 16;
  localparam int DEB_RESET = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0;
  logic             write = 1'b0;
  logic [2:0]       addr = '0;
  logic [31:0]      wdata = '0;
  logic             ready;
  logic [31:0]      rdata;
  logic [WIDTH-1:0] pins_in = '0;
  logic [WIDTH-1:0] pins_w;
  logic [WIDTH-1:0] pins_oe;
  logic             irq;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  gpio_pad_bank #(.WIDTH(WIDTH), .DEB_W(DEB_W), .DEB_RESET(DEB_RESET)) dut (
    .io_clock(clk),
    .io_reset(rst),
    .io_bus_valid(valid),
    .io_bus_write(write),
    .io_bus_addr(addr),
    .io_bus_wdata(wdata),
    .io_bus_ready(ready),
    .io_bus_rdata(rdata),
    .io_pins_read(pins_in),
    .io_pins_write(pins_w),
    .io_pins_writeEnable(pins_oe),
    .io_interrupt(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    @(posedge clk); #1;
    valid = 1'b1; write = wr; addr = a; wdata = d;
    @(posedge clk); #1;
    valid = 1'b0; write = 1'b0;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL bus_ready addr=%0d got=%b want=1", a, ready);
    end
    rd = rdata;
    $display("bus %s addr=%0d wdata=%h rdata=%h", wr ? "WR" : "RD", a, d, rdata);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [2:0]  ra [4] = '{3'd7, 3'd1, 3'd2, 3'd6};
    logic [31:0] re [4] = '{32'(DEB_RESET), 32'h0, 32'h0, 32'h0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus_xfer(1'b1, 3'd2, 32'hFF, rd);
    bus_xfer(1'b1, 3'd1, 32'hA5, rd);
    bus_xfer(1'b0, 3'd1, 32'h0, rd);
    @(posedge clk); #1;
    valid = 1'b1; write = 1'b0; addr = 3'd1;
    @(posedge clk); #2;
    exp_q.push_back(32'hA5);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (ready !== 1'b1 || rdata !== exp_v || pins_w !== 8'hA5) begin
      n_err++;
      $display("FAIL pre_reset ready=%b rdata=%h pins_w=%h want 1/%h/a5", ready, rdata, pins_w, exp_v);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ready, rdata, pins_w, pins_oe, irq} !== '0) begin
      n_err++;
      $display("FAIL async_reset ready=%b rdata=%h pins_w=%h pins_oe=%h irq=%b want all 0",
               ready, rdata, pins_w, pins_oe, irq);
    end
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(re[i]);
      bus_xfer(1'b0, ra[i], 32'h0, rd);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (rd !== exp_v) begin
        n_err++;
        $display("FAIL reset_value addr=%0d got=%h want=%h", ra[i], rd, exp_v);
      end
    end
  endtask

  task automatic test_push_pull();
    logic [31:0] rd;
    bus_xfer(1'b1, 3'd7, 32'h0, rd);
    bus_xfer(1'b1, 3'd2, 32'hFF, rd);
    bus_xfer(1'b1, 3'd1, 32'hA5, rd);
    exp_q.push_back(32'h0);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pins_w !== exp_v[WIDTH-1:0]) begin
      n_err++;
      $display("FAIL pp_latency pins_w=%h want=%h", pins_w, exp_v[WIDTH-1:0]);
    end
    exp_q.push_back({16'h0, 8'hFF, 8'hA5});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pins_oe !== exp_v[15:8] || pins_w !== exp_v[7:0]) begin
      n_err++;
      $display("FAIL push_pull oe=%h w=%h want oe=%h w=%h", pins_oe, pins_w, exp_v[15:8], exp_v[7:0]);
    end
  endtask

  task automatic test_open_drain();
    logic [31:0] rd;
    logic [7:0]  out_v [2] = '{8'h00, 8'h01};
    logic [15:0] exp_p [2] = '{{8'h01, 8'h00}, {8'h00, 8'h00}};
    bus_xfer(1'b1, 3'd1, 32'h0, rd);
    bus_xfer(1'b1, 3'd3, 32'h01, rd);
    bus_xfer(1'b1, 3'd2, 32'h01, rd);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({16'h0, exp_p[i]});
      bus_xfer(1'b1, 3'd1, {24'h0, out_v[i]}, rd);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (pins_oe !== exp_v[15:8] || pins_w !== exp_v[7:0]) begin
        n_err++;
        $display("FAIL open_drain out=%h oe=%h w=%h want oe=%h w=%h",
                 out_v[i], pins_oe, pins_w, exp_v[15:8], exp_v[7:0]);
      end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    int len;
    bus_xfer(1'b1, 3'd7, 32'd4, rd);
    for (int run = 0; run < 2; run++) begin
      len = (run == 0) ? 4 : 5;
      repeat (20) @(posedge clk);
      #1 pins_in[0] = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back((run == 0) ? 32'h0 : 32'h1);
      exp_q.push_back((run == 0) ? 32'h0 : 32'h1);
      exp_q.push_back(32'h0);
      for (int e = 0; e <= 12; e++) begin
        @(posedge clk); #1;
        if (e == len - 1) pins_in[0] = 1'b0;
        if (e == 5) begin
          valid = 1'b1; write = 1'b0; addr = 3'd0;
        end
        if (e == 6 || e == 8 || e == 10 || e == 12) begin
          exp_v = exp_q.pop_front();
          n_cmp++;
          if (ready !== 1'b1 || rdata !== exp_v) begin
            n_err++;
            $display("FAIL debounce len=%0d edge=%0d ready=%b rdata=%h want 1/%h",
                     len, e, ready, rdata, exp_v);
          end
          $display("debounce len=%0d edge=%0d IN=%h", len, e, rdata);
        end
        if (e == 7) begin
          n_cmp++;
          if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL held_valid_gap ready=%b want=0", ready);
          end
        end
        if (e == 12) valid = 1'b0;
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    bus_xfer(1'b1, 3'd7, 32'h0, rd);
    bus_xfer(1'b1, 3'd4, 32'h02, rd);
    @(posedge clk); #1 pins_in[1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    exp_q.push_back(32'h1);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (irq !== exp_v[0]) begin
      n_err++;
      $display("FAIL irq_rise irq=%b want=%b", irq, exp_v[0]);
    end
    exp_q.push_back(32'h02);
    bus_xfer(1'b0, 3'd6, 32'h0, rd);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd !== exp_v) begin
      n_err++;
      $display("FAIL pending_rise got=%h want=%h", rd, exp_v);
    end
    bus_xfer(1'b1, 3'd6, 32'h02, rd);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_drop_latency irq=%b want=1", irq);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_drop irq=%b want=0", irq);
    end
    pins_in[1] = 1'b0;
    repeat (6) @(posedge clk);
    exp_q.push_back(32'h0);
    bus_xfer(1'b0, 3'd6, 32'h0, rd);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd !== exp_v) begin
      n_err++;
      $display("FAIL pending_w1c got=%h want=%h", rd, exp_v);
    end
    // Rise reaches PENDING on the 4th edge after the pad change; the W1C is timed to that edge.
    @(posedge clk); #1 pins_in[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    valid = 1'b1; write = 1'b1; addr = 3'd6; wdata = 32'h02;
    @(posedge clk); #1;
    valid = 1'b0; write = 1'b0;
    exp_q.push_back(32'h02);
    bus_xfer(1'b0, 3'd6, 32'h0, rd);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd !== exp_v || irq !== 1'b1) begin
      n_err++;
      $display("FAIL set_wins pending=%h irq=%b want %h/1", rd, irq, exp_v);
    end
    bus_xfer(1'b1, 3'd4, 32'h0, rd);
    exp_q.push_back(32'h02);
    bus_xfer(1'b0, 3'd6, 32'h0, rd);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd !== exp_v) begin
      n_err++;
      $display("FAIL enable_clear_keeps got=%h want=%h", rd, exp_v);
    end
    bus_xfer(1'b1, 3'd6, 32'hFF, rd);
  endtask

  task automatic test_bus();
    logic [31:0] rd;
    logic [31:0] v;
    logic [2:0]  ra [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) begin
        v = $urandom;
        bus_xfer(1'b1, ra[i], v, rd);
        exp_q.push_back((ra[i] == 3'd7) ? (v & 32'hFFFF) : (v & 32'hFF));
        bus_xfer(1'b0, ra[i], 32'h0, rd);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd !== exp_v) begin
          n_err++;
          $display("FAIL readback addr=%0d got=%h want=%h", ra[i], rd, exp_v);
        end
      end
    end
    bus_xfer(1'b1, 3'd0, 32'hFF, rd);
    exp_q.push_back({24'h0, pins_in});
    bus_xfer(1'b0, 3'd0, 32'h0, rd);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (rd !== exp_v) begin
      n_err++;
      $display("FAIL in_write_ignored got=%h want=%h", rd, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_push_pull();
    test_open_drain();
    test_debounce();
    test_irq();
    test_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
